ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous RAM, with per-requester read response holding.
// Optional macro RAM_ARB_FIXED_PRIO_EN: requester 0 always wins ties (default build is round-robin).
module ram_arbiter #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 14
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [AWIDTH-1:0] req0_addr,
    input  logic [DWIDTH-1:0] req0_wdata,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DWIDTH-1:0] rsp0_rdata,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [AWIDTH-1:0] req1_addr,
    input  logic [DWIDTH-1:0] req1_wdata,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DWIDTH-1:0] rsp1_rdata,

    output logic              ram_en,
    output logic              ram_we,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0] ram_d,
    input  logic [DWIDTH-1:0] ram_q
);

    logic inflight0, inflight1;
    logic elig0, elig1;
    logic grant0, grant1;

`ifndef RAM_ARB_FIXED_PRIO_EN
    logic last_grant;
`endif

    // A read is only eligible once the previous response of that requester is fully drained,
    // so at most one read is ever in flight and ram_q always belongs to the single flagged requester.
    always_comb begin
        elig0  = req0_valid && (req0_we || (!inflight0 && !rsp0_valid));
        elig1  = req1_valid && (req1_we || (!inflight1 && !rsp1_valid));
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n) begin
            if (elig0 && elig1) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
                grant0 = 1'b1;
`else
                grant0 = last_grant;
                grant1 = !last_grant;
`endif
            end else begin
                grant0 = elig0;
                grant1 = elig1;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        ram_en   = grant0 || grant1;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_d    = '0;
        if (grant0) begin
            ram_we   = req0_we;
            ram_addr = req0_addr;
            ram_d    = req0_wdata;
        end else if (grant1) begin
            ram_we   = req1_we;
            ram_addr = req1_addr;
            ram_d    = req1_wdata;
        end
    end

    // In-flight lasts exactly one cycle: the cycle in which the RAM presents the read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight0  <= 1'b0;
            inflight1  <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_rdata <= '0;
        end else begin
            inflight0 <= grant0 && !req0_we;
            inflight1 <= grant1 && !req1_we;

            if (inflight0) begin
                rsp0_rdata <= ram_q;
                rsp0_valid <= 1'b1;
            end else if (rsp0_valid && rsp0_ready) begin
                rsp0_valid <= 1'b0;
            end

            if (inflight1) begin
                rsp1_rdata <= ram_q;
                rsp1_valid <= 1'b1;
            end else if (rsp1_valid && rsp1_ready) begin
                rsp1_valid <= 1'b0;
            end
        end
    end

`ifndef RAM_ARB_FIXED_PRIO_EN
    // Pointer names the most recent winner; reset to 1 so requester 0 takes the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (grant0) begin
            last_grant <= 1'b0;
        end else if (grant1) begin
            last_grant <= 1'b1;
        end
    end
`endif

endmodule
